alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Controller that runs one ALU operation per request over the shared 16-bit bus. It drives operand A onto the bus and pulses the ALU's first-operand latch enable, then does the same for operand B with the second-operand latch enable. It then applies the opcode, enables the ALU bus output, captures the result and returns it to the requester. It sits between an instruction/control unit (request side) and the ALU plus its bus (datapath side).

Parameters:
DATA_W, 16, bus and operand width
OP_W, 4, ALU opcode width
SETTLE_CYCLES, 1, cycles the EXEC state holds before sampling bus_in (legal range 1..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge
req_valid  input  1  request present
req_ready  output  1  sequencer can accept request
req_op  input  OP_W  ALU opcode
req_a  input  DATA_W  operand A
req_b  input  DATA_W  operand B (ignored for NOT)
rsp_valid  output  1  result available
rsp_ready  input  1  requester takes result
rsp_data  output  DATA_W  ALU result
rsp_err  output  1  request had illegal opcode
bus_drv  output  DATA_W  data sequencer places on shared bus
bus_drv_en  output  1  enables sequencer's bus tri-state driver
bus_in  input  DATA_W  shared bus value
alu_latch1_en  output  1  ALU first-operand latch enable
alu_latch2_en  output  1  ALU second-operand latch enable
alu_control  output  OP_W  ALU opcode
alu_out_en  output  1  ALU bus output enable
busy  output  1  state != IDLE

Behaviour:
- Opcodes: 1 ADD, 2 SUB, 3 NOT (unary), 4 AND, 5 OR, 6 XOR, 7 XNOR. 0 and 8..15 are illegal.
- States: IDLE, LOAD_A, LOAD_B, EXEC, RESP. All outputs are registered or decoded from the state register only.
- Reset (reset=0 at edge): state goes to IDLE. Every output is 0, including req_ready. req_ready=1 from the first cycle after reset is released.
- IDLE: req_ready=1. On req_valid&req_ready, capture op/a/b.
  - Legal opcode: go to LOAD_A.
  - Illegal opcode: go to RESP with rsp_err=1 and rsp_data=0. No bus activity.
- LOAD_A (1 cycle): bus_drv=a, bus_drv_en=1, alu_latch1_en=1. Next state is EXEC if op=NOT, else LOAD_B.
- LOAD_B (1 cycle): bus_drv=b, bus_drv_en=1, alu_latch2_en=1. Next state is EXEC.
- EXEC: alu_control=op, alu_out_en=1, bus_drv_en=0. A down-counter loaded with SETTLE_CYCLES-1 runs here. When the counter reaches 0, bus_in is registered into rsp_data and the state goes to RESP.
- RESP: rsp_valid=1, and rsp_data/rsp_err are held stable until rsp_ready=1. Then go to IDLE.
  - The handshake completing in the RESP cycle returns to IDLE, and req_ready=1 in the following cycle. There is no request/response overlap.
- Outside their states, alu_control=0, bus_drv=0, and all enables are 0.
- Invariants:
  - bus_drv_en and alu_out_en are never both 1.
  - alu_latch1_en and alu_latch2_en are never both 1.
  - Enables are 1-cycle pulses per state visit.
- Latency from the accept edge to rsp_valid high, with SETTLE_CYCLES=1:
  - binary op: 4 cycles
  - NOT: 3 cycles
  - illegal op: 1 cycle
  - Each additional SETTLE cycle adds 1.
- Arithmetic is performed by the ALU. Wrap-around (mod 2^DATA_W) is passed through unmodified.
- Reset mid-operation: the in-flight result is discarded, no rsp_valid is produced, and all bus/ALU enables drop on the same edge.
- req_valid while busy: ignored (req_ready=0). The requester must hold the request.

Optional Feature:
ALU_SEQ_FLAGS_EN.
- Defined: adds outputs rsp_zero (rsp_data==0) and rsp_neg (rsp_data[DATA_W-1]). Both are registered together with rsp_data, valid with rsp_valid, and 0 on reset and for illegal opcodes.
- Undefined: the ports do not exist and there is no flag logic.

Decomposition:
- Package alu_seq_pkg: OP_ADD..OP_XNOR constants, the state enumeration, default DATA_W/OP_W, and an is_legal_op/is_unary_op function.
- No sub-module. The settle counter and FSM stay inline.
- The bus tri-state is instantiated outside, using the existing tri_state_buffer driven by bus_drv/bus_drv_en.

Test Plan:
- ADD a=0x1234 b=0x0101, rsp_ready=1 -> LOAD_A/LOAD_B/EXEC pulses in order. rsp_valid 4 cycles after accept. rsp_data=0x1335, rsp_err=0.
- SUB a=0x0000 b=0x0001 -> rsp_data=0xFFFF (wrap). With flags enabled: rsp_neg=1, rsp_zero=0.
- NOT a=0x00FF -> no alu_latch2_en pulse. rsp_valid after 3 cycles. rsp_data=0xFF00.
- Illegal op 0x9 -> rsp_valid next cycle with rsp_err=1, rsp_data=0. bus_drv_en, latches and alu_out_en stay 0 throughout.
- XOR 0xAAAA^0xAAAA with rsp_ready held 0 for 5 cycles:
  - rsp_data=0x0000 stable, and rsp_zero=1 if flags enabled.
  - req_ready=0 and a second req_valid is ignored.
  - After rsp_ready=1, return to IDLE.
- reset=0 asserted during EXEC -> next cycle all outputs 0 and state IDLE, no rsp_valid. A subsequent AND 0xF0F0&0x0FF0 returns 0x00F0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states, default widths and opcode classifiers for alu_sequencer.
package alu_seq_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int OP_W_DEF = 4;
    localparam logic [OP_W_DEF-1:0] OP_ADD = 4'd1;
    localparam logic [OP_W_DEF-1:0] OP_SUB = 4'd2;
    localparam logic [OP_W_DEF-1:0] OP_NOT = 4'd3;
    localparam logic [OP_W_DEF-1:0] OP_AND = 4'd4;
    localparam logic [OP_W_DEF-1:0] OP_OR = 4'd5;
    localparam logic [OP_W_DEF-1:0] OP_XOR = 4'd6;
    localparam logic [OP_W_DEF-1:0] OP_XNOR = 4'd7;
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, RESP} state_t;
    function automatic logic is_legal_op(input logic [OP_W_DEF-1:0] op);
        return op >= OP_ADD && op <= OP_XNOR;
    endfunction
    function automatic logic is_unary_op(input logic [OP_W_DEF-1:0] op);
        return op == OP_NOT;
    endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake plus shared-bus and ALU control for alu_sequencer.
// ALU_SEQ_FLAGS_EN adds the rsp_zero/rsp_neg result flags.
interface alu_seq_if import alu_seq_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W = OP_W_DEF
);
    logic req_valid;
    logic req_ready;
    logic [OP_W-1:0] req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic rsp_valid;
    logic rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic rsp_err;
    logic [DATA_W-1:0] bus_drv;
    logic bus_drv_en;
    logic [DATA_W-1:0] bus_in;
    logic alu_latch1_en;
    logic alu_latch2_en;
    logic [OP_W-1:0] alu_control;
    logic alu_out_en;
    logic busy;
`ifdef ALU_SEQ_FLAGS_EN
    logic rsp_zero;
    logic rsp_neg;
`endif
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, bus_in,
        input req_ready, rsp_valid, rsp_data, rsp_err, bus_drv, bus_drv_en,
        input alu_latch1_en, alu_latch2_en, alu_control, alu_out_en, busy
`ifdef ALU_SEQ_FLAGS_EN
        , input rsp_zero, rsp_neg
`endif
    );
    modport slave (
        input req_valid, req_op, req_a, req_b, rsp_ready, bus_in,
        output req_ready, rsp_valid, rsp_data, rsp_err, bus_drv, bus_drv_en,
        output alu_latch1_en, alu_latch2_en, alu_control, alu_out_en, busy
`ifdef ALU_SEQ_FLAGS_EN
        , output rsp_zero, rsp_neg
`endif
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences operand loads, ALU execute and result return over a shared bus.
// Define ALU_SEQ_FLAGS_EN to add registered rsp_zero/rsp_neg result flags.
module alu_sequencer import alu_seq_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W = OP_W_DEF,
    parameter int SETTLE_CYCLES = 1
) (
    input logic clk,
    input logic reset,
    alu_seq_if.slave io
);
    state_t state, state_nxt;
    logic live;
    logic [OP_W-1:0] op_q;
    logic [DATA_W-1:0] a_q, b_q, data_q;
    logic err_q;
    logic [3:0] cnt;
    logic accept, exec_done;
    // live keeps req_ready low for the whole time reset is held, even though state is already IDLE
    assign accept = state == IDLE && live && io.req_valid;
    assign exec_done = state == EXEC && cnt == 4'd0;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            live <= 1'b0;
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            data_q <= '0;
            err_q <= 1'b0;
            cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            live <= 1'b1;
            if (accept) begin
                op_q <= io.req_op;
                a_q <= io.req_a;
                b_q <= io.req_b;
                data_q <= '0;
                err_q <= !is_legal_op(io.req_op);
            end
            if (state_nxt == EXEC && state != EXEC) cnt <= 4'(SETTLE_CYCLES - 1);
            else if (state == EXEC && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (exec_done) data_q <= io.bus_in;
        end
    end
    always_comb begin
        state_nxt = state == IDLE ? (accept ? (is_legal_op(io.req_op) ? LOAD_A : RESP) : IDLE)
                  : state == LOAD_A ? (is_unary_op(op_q) ? EXEC : LOAD_B)
                  : state == LOAD_B ? EXEC
                  : state == EXEC ? (exec_done ? RESP : EXEC)
                  : (state == RESP && !io.rsp_ready) ? RESP : IDLE;
        io.req_ready = state == IDLE && live;
        io.rsp_valid = state == RESP;
        io.rsp_data = data_q;
        io.rsp_err = err_q;
        io.bus_drv_en = state == LOAD_A || state == LOAD_B;
        io.bus_drv = state == LOAD_A ? a_q : state == LOAD_B ? b_q : '0;
        io.alu_latch1_en = state == LOAD_A;
        io.alu_latch2_en = state == LOAD_B;
        io.alu_control = state == EXEC ? op_q : '0;
        io.alu_out_en = state == EXEC;
        io.busy = state != IDLE;
    end
`ifdef ALU_SEQ_FLAGS_EN
    logic zero_q, neg_q;
    always_ff @(posedge clk) begin
        if (!reset || accept) begin
            zero_q <= 1'b0;
            neg_q <= 1'b0;
        end else if (exec_done) begin
            zero_q <= io.bus_in == '0;
            neg_q <= io.bus_in[DATA_W-1];
        end
    end
    assign io.rsp_zero = zero_q;
    assign io.rsp_neg = neg_q;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed table, reset-abort sequence and random ops against an ALU/bus model.
module tb_alu_sequencer;
    localparam int DW = 16;
    localparam int OW = 4;
    localparam int SETTLE = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.DATA_W(DW), .OP_W(OW)) bus();
    alu_sequencer #(.DATA_W(DW), .OP_W(OW), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk),
        .reset(reset),
        .io(bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            4'd1: return a + b;
            4'd2: return a - b;
            4'd3: return ~a;
            4'd4: return a & b;
            4'd5: return a | b;
            4'd6: return a ^ b;
            4'd7: return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    // ALU and shared bus: floating bus reads as random junk
    logic [DW-1:0] l1 = '0, l2 = '0, junk = '0, bus_val;
    assign bus_val = bus.bus_drv_en ? bus.bus_drv : junk;
    always @(posedge clk) begin
        junk <= DW'($urandom);
        if (bus.alu_latch1_en) l1 <= bus_val;
        if (bus.alu_latch2_en) l2 <= bus_val;
    end
    assign bus.bus_in = bus.alu_out_en ? alu_f(bus.alu_control, l1, l2) : junk;

    int n_l1 = 0, n_l2 = 0, n_oe = 0, n_de = 0, inv_bad = 0, cyc = 0, t_l1 = 0, t_l2 = 0, t_oe = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.alu_latch1_en) begin n_l1++; t_l1 = cyc; end
        if (bus.alu_latch2_en) begin n_l2++; t_l2 = cyc; end
        if (bus.alu_out_en) begin n_oe++; t_oe = cyc; end
        if (bus.bus_drv_en) n_de++;
        if ((bus.bus_drv_en && bus.alu_out_en) || (bus.alu_latch1_en && bus.alu_latch2_en) ||
            (!bus.bus_drv_en && bus.bus_drv != '0) || (!bus.alu_out_en && bus.alu_control != '0))
            inv_bad++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold,
                       input logic [DW-1:0] exp_d, input logic exp_e, input int exp_lat);
        int s1, s2, so, sd, si, lat, w;
        logic legal, unary;
        logic [DW-1:0] d0;
        legal = op >= 4'd1 && op <= 4'd7;
        unary = op == 4'd3;
        @(negedge clk);
        w = 0;
        while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
        chk("req_ready_idle", 32'(bus.req_ready), 1);
        s1 = n_l1; s2 = n_l2; so = n_oe; sd = n_de; si = inv_bad;
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_a = a;
        bus.req_b = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op = 4'($urandom);
        bus.req_a = DW'($urandom);
        bus.req_b = DW'($urandom);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 100);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_data", 32'(bus.rsp_data), 32'(exp_d));
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_e));
`ifdef ALU_SEQ_FLAGS_EN
        chk("rsp_zero", 32'(bus.rsp_zero), 32'(!exp_e && exp_d == '0));
        chk("rsp_neg", 32'(bus.rsp_neg), 32'(!exp_e && exp_d[DW-1]));
`endif
        d0 = bus.rsp_data;
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op = 4'd1;
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 1);
            chk("hold_data", 32'(bus.rsp_data), 32'(d0));
            chk("hold_ready", 32'(bus.req_ready), 0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_done", 32'(bus.rsp_valid), 0);
        chk("back_idle", {30'd0, bus.req_ready, bus.busy}, 32'b10);
        chk("latch1_pulses", 32'(n_l1 - s1), 32'(legal));
        chk("latch2_pulses", 32'(n_l2 - s2), 32'(legal && !unary));
        chk("out_en_cycles", 32'(n_oe - so), legal ? 32'(SETTLE) : 0);
        chk("drv_en_cycles", 32'(n_de - sd), !legal ? 0 : unary ? 1 : 2);
        chk("invariants", 32'(inv_bad - si), 0);
        if (legal && !unary) chk("pulse_order", {16'(t_l2 - t_l1), 16'(t_oe - t_l2)}, {16'd1, 16'd1});
    endtask

    typedef struct {
        logic [3:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int hold;
        logic [DW-1:0] d;
        logic e;
        int lat;
    } vec_t;

    initial begin
        vec_t tv[11];
        int w;
        logic seen;
        tv[0] = '{4'd1, 16'h1234, 16'h0101, 0, 16'h1335, 1'b0, 4};
        tv[1] = '{4'd2, 16'h0000, 16'h0001, 0, 16'hFFFF, 1'b0, 4};
        tv[2] = '{4'd3, 16'h00FF, 16'h1234, 0, 16'hFF00, 1'b0, 3};
        tv[3] = '{4'd9, 16'h1111, 16'h2222, 0, 16'h0000, 1'b1, 1};
        tv[4] = '{4'd6, 16'hAAAA, 16'hAAAA, 5, 16'h0000, 1'b0, 4};
        tv[5] = '{4'd4, 16'hF0F0, 16'h0FF0, 0, 16'h00F0, 1'b0, 4};
        tv[6] = '{4'd5, 16'hF000, 16'h000F, 1, 16'hF00F, 1'b0, 4};
        tv[7] = '{4'd7, 16'hFF00, 16'h0F0F, 0, 16'h0FF0, 1'b0, 4};
        tv[8] = '{4'd0, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 1'b1, 1};
        tv[9] = '{4'd15, 16'h8000, 16'h0001, 2, 16'h0000, 1'b1, 1};
        tv[10] = '{4'd1, 16'hFFFF, 16'h0001, 2, 16'h0000, 1'b0, 4};
        bus.req_valid = 1'b0;
        bus.req_op = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {24'd0, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.bus_drv_en,
                           bus.alu_latch1_en, bus.alu_latch2_en, bus.alu_out_en, bus.busy}, 0);
        chk("reset_data", {bus.rsp_data, bus.bus_drv}, 0);
        chk("reset_alu_control", 32'(bus.alu_control), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.req_ready), 1);

        for (int i = 0; i < 11; i++) run(tv[i].op, tv[i].a, tv[i].b, tv[i].hold, tv[i].d, tv[i].e, tv[i].lat);

        // abort an ADD while the ALU is driving the bus
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op = 4'd1;
        bus.req_a = 16'h1234;
        bus.req_b = 16'h5678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!bus.alu_out_en && w < 20);
        chk("reach_exec", 32'(bus.alu_out_en), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ctrl", {24'd0, bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.bus_drv_en,
                           bus.alu_latch1_en, bus.alu_latch2_en, bus.alu_out_en, bus.busy}, 0);
        chk("abort_data", {bus.rsp_data, bus.bus_drv}, 0);
        chk("abort_alu_control", 32'(bus.alu_control), 0);
        reset = 1'b1;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); seen |= bus.rsp_valid | bus.busy; end
        chk("no_rsp_after_abort", 32'(seen), 0);
        run(4'd4, 16'hF0F0, 16'h0FF0, 0, 16'h00F0, 1'b0, 4);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            logic [DW-1:0] a, b;
            logic legal;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(1, 7));
            a = DW'($urandom);
            b = DW'($urandom);
            legal = op >= 4'd1 && op <= 4'd7;
            run(op, a, b, $urandom_range(0, 2), legal ? alu_f(op, a, b) : '0, !legal,
                !legal ? 1 : (op == 4'd3 ? 2 : 3) + SETTLE);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
